// File: rtl/riscv_pkg.sv
// Shared RV32I load/store funct3 encodings and the data-memory responder state type.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enables and a registered read.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memoria_dados_resp.sv
// Load/store responder for the MEM stage: request handshake, WAIT_CYCLES wait states, byte-lane
// stores and extended loads. Define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses.
module memoria_dados_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        accept;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        f3_ok, range_err, misalign, acc_err;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << a;
            F3_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            F3_SB:   lanes = {4{wd[7:0]}};
            F3_SH:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        ext;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   ext = 32'(b);
            F3_LH:   ext = 32'(h);
            F3_LBU:  ext = {24'd0, $unsigned(b)};
            F3_LHU:  ext = {16'd0, $unsigned(h)};
            default: ext = word;
        endcase
        return ext;
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ACCESS;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ACCESS;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCESS: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        if (we_q) begin
            f3_ok = (f3_q == F3_SB) || (f3_q == F3_SH) || (f3_q == F3_SW);
        end else begin
            f3_ok = (f3_q == F3_LB) || (f3_q == F3_LH) || (f3_q == F3_LW) ||
                    (f3_q == F3_LBU) || (f3_q == F3_LHU);
        end
        range_err = (addr_q[31:2] >= 30'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
        case (f3_q)
            F3_LH, F3_LHU: misalign = addr_q[0];
            F3_LW:         misalign = (addr_q[1:0] != 2'b00);
            default:       misalign = 1'b0;
        endcase
`else
        misalign = 1'b0;
`endif
        acc_err = !f3_ok || range_err || misalign;
    end

    // The RAM reads the incoming address while idle so data is ready in ACCESS even with no wait states.
    assign ram_addr  = (state == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign ram_we    = (state == ACCESS) && we_q && !acc_err;
    assign ram_be    = store_be(f3_q, addr_q[1:0]);
    assign ram_wdata = store_lanes(f3_q, wdata_q);

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == ACCESS) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_ext(f3_q, addr_q[1:0], ram_rdata);
            end
        end
    end

    // Request fields are plain data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Scoreboard bench for memoria_dados_resp: byte-addressed reference model, directed and random traffic.
module tb_memoria_dados_resp;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, busy;

    memoria_dados_resp #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          acyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  mem_b[longint];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, widths and signs from the RV32I rules.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int     n = 0;
        bit     sgn = 0;
        bit     ok = 0;
        longint a = longint'(addr);
        longint base, v;
        case (f3)
            3'd0: begin n = 1; sgn = 1; ok = 1; end
            3'd1: begin n = 2; sgn = 1; ok = 1; end
            3'd2: begin n = 4; ok = 1; end
            3'd4: begin n = 1; ok = !we; end
            3'd5: begin n = 2; ok = !we; end
            default: ok = 0;
        endcase
        err = !ok || (a / 4 >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (ok && (a % n) != 0) err = 1;
`endif
        rd = 32'd0;
        if (!err) begin
            base = a - (a % n);
            if (we) begin
                for (int i = 0; i < n; i++) mem_b[base + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(mem_b[base + i]) << (8 * i);
                if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        exp_t e;
        int   t;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = (hold == 0);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wd, e.rd, e.err);
        @(posedge clk);
        @(negedge clk);
        e.acyc = cyc;
        sb_q.push_back(e);
        req_valid = 1'b0;
        req_wdata = $urandom;
        t = 0;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            check("rsp_timeout", 32'd1, 32'd0);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: pops one expectation per response and re-checks it every cycle the response is held.
    initial begin
        exp_t cur;
        bit   prev_v = 0;
        cur.rd = 0; cur.err = 0; cur.acyc = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (!prev_v) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("latency", 32'(cyc - cur.acyc), 32'(WAITC + 1));
                    end
                end
                check("rsp_rdata", rsp_rdata, cur.rd);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                check("busy_in_resp", {31'd0, busy}, 32'd1);
            end
            prev_v = rsp_valid;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 3'd2, 32'h10, 32'h0, 0);
        do_req(1, 3'd0, 32'h13, 32'h00000080, 1);
        do_req(0, 3'd0, 32'h13, 32'h0, 0);
        do_req(0, 3'd4, 32'h13, 32'h0, 0);
        do_req(0, 3'd2, 32'h10, 32'h0, 0);
        do_req(0, 3'd1, 32'h12, 32'h0, 0);
        do_req(0, 3'd5, 32'h12, 32'h0, 0);
        do_req(0, 3'd2, 32'h12, 32'h0, 0);
        do_req(1, 3'd2, 32'h11, 32'hA5A5A5A5, 0);
        do_req(0, 3'd2, 32'h10, 32'h0, 0);
        do_req(0, 3'd2, DEPTH * 4, 32'h0, 0);
        do_req(0, 3'd3, 32'h10, 32'h0, 0);
        do_req(1, 3'd4, 32'h10, 32'hFFFFFFFF, 0);
        do_req(0, 3'd2, 32'h10, 32'h0, 5);
        do_req(0, 3'd1, 32'h10, 32'h0, 0);

        do_req(1, 3'd2, 32'h20, 32'hCAFEF00D, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h12345678; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req(0, 3'd2, 32'h20, 32'h0, 0);

        for (int w = 0; w < 16; w++) do_req(1, 3'd2, 32'(w * 4), $urandom, 0);
        for (int k = 0; k < 150; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = DEPTH * 4 + $urandom_range(0, 4095);
            else a = $urandom_range(0, 63);
            do_req(we, f3, a, $urandom, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memoria_dados_resp.md
# memoria_dados_resp

Data-memory responder serving the load/store requests issued by the pipeline's MEM stage. It accepts one request at a time over a valid/ready handshake and applies a configurable number of wait states. It performs RV32I byte/half/word stores with byte enables, and sign- or zero-extends loads. Each result returns over a second valid/ready channel, so the MEM stage can stall on memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 1024: storage size in 32-bit words; power of two.
- WAIT_CYCLES, 2: extra cycles between request acceptance and the RAM access; range 0..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 for the load/store width and sign.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; used bits start at bit 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  invalid funct3, out-of-range address or misaligned access (see Configuration).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we, funct3, addr and wdata.
  - Go to WAIT with the counter at WAIT_CYCLES-1, or go to ACCESS if WAIT_CYCLES=0.
- WAIT: decrement the counter; when it reaches 0, go to ACCESS. Request inputs are ignored.
- ACCESS (one cycle): check the request, then perform it.
  - Error checks, each sets err=1 with no write and rdata=0:
    - word index addr[31:2] >= DEPTH_WORDS;
    - load funct3 not in {0,1,2,4,5};
    - store funct3 not in {0,1,2}.
  - Store:
    - SB: byte lane addr[1:0].
    - SH: lanes addr[1]*2 and +1.
    - SW: all lanes.
    - Only the enabled bytes are written, at the end of ACCESS.
  - Load:
    - Synchronous word read.
    - LB/LH sign-extend; LBU/LHU zero-extend.
    - Lane selection is the same as for stores.
    - Result is registered into rsp_rdata on entry to RESP.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_ready that arrives before RESP is ignored.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; state=IDLE.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: at most one request per WAIT_CYCLES+3 cycles, including the IDLE cycle after the response handshake. There is no request/response overlap.
- Backpressure: rsp_valid stays high indefinitely while rsp_ready=0.
- Store commit: the write happens at the ACCESS→RESP edge. A later load sees the new data.
- Reset mid-operation:
  - Before the ACCESS edge, the store is not committed.
  - In any state, outputs return to reset values immediately (asynchronously).
  - A response in flight is lost.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, give rsp_err=1, no write and rsp_rdata=0.
- Not defined:
  - Misaligned addresses are silently aligned: halfword uses addr[1] only, word ignores addr[1:0].
  - rsp_err flags only invalid funct3 and out-of-range addresses.

## Structure
- Shared package riscv_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW;
  - the state enum dmem_state_t {IDLE, WAIT, ACCESS, RESP}.
- Sub-module dmem_ram:
  - DEPTH_WORDS×32 storage;
  - 4-bit byte-enable write;
  - synchronous read, one port.
- memoria_dados_resp holds the FSM, the checks, lane steering and extension.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 (WAIT_CYCLES=2) → rdata 0xDEADBEEF, err=0. rsp_valid rises exactly 3 cycles after each accept; req_ready=0 until the response handshake.
- After the above, SB 0x80 to 0x13 → LB 0x13 gives 0xFFFFFF80, LBU 0x13 gives 0x00000080, LW 0x10 gives 0x80ADBEEF, LH 0x12 gives 0xFFFF80AD, LHU 0x12 gives 0x000080AD.
- LW at 0x12, with the macro defined → err=1, rdata 0. Without the macro → rdata equals the word at 0x10. Macro defined, SW at 0x11 → err=1 and memory unchanged.
- Out of range: LW at DEPTH_WORDS*4 → err=1, rdata 0. Invalid funct3=3 load → err=1.
- Backpressure: rsp_ready held low for 5 cycles in RESP → rsp_valid, rdata and err stay stable and req_ready=0. The request is accepted the cycle after IDLE is re-entered.
- SW 0x12345678 to 0x20, with reset asserted during WAIT → outputs go to reset values at once. A following LW 0x20 returns the prior contents, not 0x12345678.
